// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam int unsigned SERIAL_ADDSUB_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Combinational 1-bit full adder used as the serial datapath cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, WIDTH cycles per op.
// Optional SERIAL_ADDSUB_OVF_EN builds the signed-overflow logic; otherwise overflow is 0.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             fa_s, fa_co;
  logic             load, last;

  assign load = start && (state != RUN);
  assign last = (state == RUN) && (cnt == LAST);

  fa_cell u_fa (
    .a   (opa[0]),
    .b   (opb[0]),
    .cin (cy),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      // Subtract is a + ~b + 1: invert b and seed the carry with sub.
      opa <= a;
      opb <= b ^ {WIDTH{sub}};
      cy  <= sub;
      cnt <= '0;
    end else if (state == RUN) begin
      opa <= opa >> 1;
      opb <= opb >> 1;
      acc <= {fa_s, acc[WIDTH-1:1]};
      cy  <= fa_co;
      cnt <= cnt + CW'(1);
      if (last) begin
        result <= {fa_s, acc[WIDTH-1:1]};
        cout   <= fa_co;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // On the final bit cy is the carry into the MSB, so overflow is cy ^ carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    overflow <= 1'b0;
    else if (last) overflow <= cy ^ fa_co;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed cases plus random ops vs arithmetic model.
module tb_serial_addsub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] held_r = '0;
  logic         held_c = 1'b0;
  logic         held_o = 1'b0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on integers, independent of any serial structure.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] r, output logic c, output logic o);
    int sa, sb, sr, ua, ub;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (ms) begin
      r  = W'(ua - ub);
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = W'(ua + ub);
      c  = ((ua + ub) > 255);
      sr = sa + sb;
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    o = (sr < -128) || (sr > 127);
`else
    o = 1'b0;
`endif
  endtask

  // Call with the next posedge being the launch edge. Ends 1ns after the completion edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input int glitch);
    logic [W-1:0] er;
    logic         ec, eo;
    int           busy_n;
    model(ta, tb_v, ts, er, ec, eo);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    busy_n = 0;
    for (int i = 1; i <= int'(W); i++) begin
      if (busy) busy_n++;
      check("done_low_in_run", {31'd0, done}, 32'd0);
      check("result_held", {24'd0, result}, {24'd0, held_r});
      if (i == glitch) begin
        start = 1'b1; a = ~ta; b = 8'h5a; sub = ~ts;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_cycles", busy_n, W);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_off_at_done", {31'd0, busy}, 32'd0);
    check("result", {24'd0, result}, {24'd0, er});
    check("cout", {31'd0, cout}, {31'd0, ec});
    check("overflow", {31'd0, overflow}, {31'd0, eo});
    held_r = er; held_c = ec; held_o = eo;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h35, 8'h4a, 1'b0, 0);
    @(posedge clk); #1;
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
    do_op(8'h7f, 8'h01, 1'b0, 0);
    do_op(8'hff, 8'h01, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b1, 0);

    // start during RUN must be ignored; done pulses exactly once
    do_op(8'h12, 8'h34, 1'b0, 4);
    @(posedge clk); #1;
    check("single_done", {31'd0, done}, 32'd0);
    check("no_relaunch", {31'd0, busy}, 32'd0);

    // back-to-back: launch in DONE cycle
    do_op(8'h55, 8'h66, 1'b1, 0);
    do_op(8'h01, 8'h02, 1'b0, 0);

    // reset mid-run
    a = 8'h33; b = 8'h44; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", {24'd0, result}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    #2 rst_n = 1'b1;
    held_r = '0; held_c = 1'b0; held_o = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", {30'd0, busy, done}, 32'd0);
    end
    do_op(8'h0a, 8'h05, 1'b1, 0);

    // randomized ops, mixing idle gaps and back-to-back launches
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
      do_op(ra, rb, rs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
    end

    @(posedge clk); #1;
    check("final_idle", {30'd0, busy, done}, 32'd0);
    check("final_held", {24'd0, result}, {24'd0, held_r});
    check("final_cout_held", {31'd0, cout}, {31'd0, held_c});
    check("final_ovf_held", {31'd0, overflow}, {31'd0, held_o});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
